// File: rtl/vicmidi_ser_router.sv
// Routes CHANNELS UART channels onto one MIDI and one RS232 port, with a CPU register window,
// IRQ pending/mask logic and an activity LED. Optional loopback mode: VICMIDI_LOOPBACK_EN.
module vicmidi_ser_router #(
    parameter int CHANNELS  = 2,
    parameter int LED_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 r_w,
    input  logic [9:0]           address,
    input  logic                 io_sel,
    input  logic [6:0]           base,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic [CHANNELS-1:0]  uart_ce,
    input  logic [CHANNELS-1:0]  txd,
    output logic [CHANNELS-1:0]  rxd,
    input  logic [CHANNELS-1:0]  uart_irq,
    output logic                 midi_txd,
    input  logic                 midi_rxd,
    output logic                 rs232_txd,
    input  logic                 rs232_rxd,
    output logic                 irq,
    output logic                 act_led
);

    localparam int MW = 2 * CHANNELS;
    localparam logic [1:0] MODE_MIDI  = 2'b00;
    localparam logic [1:0] MODE_RS232 = 2'b01;
    localparam logic [1:0] MODE_LOOP  = 2'b10;
    localparam logic [MW-1:0] MODE_RST = {MW{1'b1}} << 2;
    localparam logic [3:0] CH_ID = 4'(CHANNELS);
`ifdef VICMIDI_LOOPBACK_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    logic [CHANNELS-1:0]  ce_next_s;
    logic                 win_sel_s;
    logic                 wr_s;
    logic                 rd_s;
    logic [7:0]           rd_data_s;
    logic [CHANNELS-1:0]  midi_own_s;
    logic [CHANNELS-1:0]  rs_own_s;
    logic [CHANNELS-1:0]  loop_s;
    logic [CHANNELS-1:0]  active_s;
    logic                 midi_found_s;
    logic                 rs_found_s;
    logic [CHANNELS-1:0]  rise_s;
    logic [CHANNELS-1:0]  clr_s;
    logic [CHANNELS-1:0]  pend_next_s;
    logic [CHANNELS-1:0]  led_edge_s;
    logic [LED_CNT_W-1:0] led_cnt_next_s;
    logic                 unused_s;

    logic [MW-1:0]        mode_r;
    logic [CHANNELS-1:0]  mask_r;
    logic [CHANNELS-1:0]  pend_r;
    logic [CHANNELS-1:0]  uart_ce_r;
    logic [7:0]           data_out_r;
    logic                 data_oe_r;
    logic                 irq_r;
    logic [CHANNELS-1:0]  irq_sync1_r;
    logic [CHANNELS-1:0]  irq_sync2_r;
    logic [CHANNELS-1:0]  irq_prev_r;
    logic [CHANNELS-1:0]  tx_sync1_r;
    logic [CHANNELS-1:0]  tx_sync2_r;
    logic [CHANNELS-1:0]  tx_prev_r;
    logic [CHANNELS-1:0]  rx_sync1_r;
    logic [CHANNELS-1:0]  rx_sync2_r;
    logic [CHANNELS-1:0]  rx_prev_r;
    logic [LED_CNT_W-1:0] led_cnt_r;
    logic                 act_led_r;

    assign unused_s = ^data_in;

    // Address decode: per-channel chip enables and the register window (7-bit wraparound).
    always_comb begin
        ce_next_s = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (!io_sel && (address[9:3] == (base + 7'(n)))) begin
                ce_next_s[n] = 1'b1;
            end else begin
                ce_next_s[n] = 1'b0;
            end
        end
        win_sel_s = !io_sel && (address[9:3] == (base + 7'(CHANNELS)));
        wr_s      = win_sel_s && !r_w;
        rd_s      = win_sel_s && r_w;
    end

    // Register read multiplexer.
    always_comb begin
        rd_data_s = 8'h00;
        case (address[2:0])
            3'd0:    rd_data_s = 8'(mode_r);
            3'd1:    rd_data_s = 8'(mask_r);
            3'd2:    rd_data_s = 8'(pend_r);
            3'd3:    rd_data_s = {4'h1, CH_ID};
            default: rd_data_s = 8'h00;
        endcase
    end

    // Port ownership: lowest-index claimant wins; losers and disabled loopback behave as off.
    always_comb begin
        midi_own_s   = '0;
        rs_own_s     = '0;
        loop_s       = '0;
        midi_found_s = 1'b0;
        rs_found_s   = 1'b0;
        for (int n = 0; n < CHANNELS; n++) begin
            if ((mode_r[2*n +: 2] == MODE_MIDI) && !midi_found_s) begin
                midi_own_s[n] = 1'b1;
                midi_found_s  = 1'b1;
            end else if ((mode_r[2*n +: 2] == MODE_RS232) && !rs_found_s) begin
                rs_own_s[n] = 1'b1;
                rs_found_s  = 1'b1;
            end else if (mode_r[2*n +: 2] == MODE_LOOP) begin
                loop_s[n] = LOOP_EN;
            end else begin
                loop_s[n] = 1'b0;
            end
        end
        active_s = midi_own_s | rs_own_s | loop_s;
    end

    // Combinational serial routing between channels and physical ports.
    always_comb begin
        midi_txd  = 1'b1;
        rs232_txd = 1'b1;
        rxd       = '1;
        for (int n = 0; n < CHANNELS; n++) begin
            if (midi_own_s[n]) begin
                midi_txd = txd[n];
                rxd[n]   = midi_rxd;
            end else if (rs_own_s[n]) begin
                rs232_txd = txd[n];
                rxd[n]    = rs232_rxd;
            end else if (loop_s[n]) begin
                rxd[n] = txd[n];
            end else begin
                rxd[n] = 1'b1;
            end
        end
    end

    // Pending update: a clear and a fresh edge on the same bit leaves the bit set.
    always_comb begin
        rise_s = irq_sync2_r & ~irq_prev_r;
        if (wr_s && (address[2:0] == 3'd2)) begin
            clr_s = data_in[CHANNELS-1:0];
        end else begin
            clr_s = '0;
        end
        pend_next_s = (pend_r & ~clr_s) | rise_s;
    end

    // LED stretch counter: reload on any line edge of an active channel, else count down to 0.
    always_comb begin
        led_edge_s = ((tx_sync2_r ^ tx_prev_r) | (rx_sync2_r ^ rx_prev_r)) & active_s;
        if (|led_edge_s) begin
            led_cnt_next_s = '1;
        end else if (led_cnt_r != '0) begin
            led_cnt_next_s = led_cnt_r - {{(LED_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            led_cnt_next_s = led_cnt_r;
        end
    end

    // Register file, bus outputs and interrupt output.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r     <= MODE_RST;
            mask_r     <= '0;
            pend_r     <= '0;
            uart_ce_r  <= '0;
            data_out_r <= 8'h00;
            data_oe_r  <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            uart_ce_r <= ce_next_s;
            pend_r    <= pend_next_s;
            irq_r     <= |(pend_r & mask_r);
            data_oe_r <= rd_s;
            if (rd_s) begin
                data_out_r <= rd_data_s;
            end
            if (wr_s && (address[2:0] == 3'd0)) begin
                mode_r <= data_in[MW-1:0];
            end
            if (wr_s && (address[2:0] == 3'd1)) begin
                mask_r <= data_in[CHANNELS-1:0];
            end
        end
    end

    // Synchronisers for IRQ and serial lines, plus the LED counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_sync1_r <= '0;
            irq_sync2_r <= '0;
            irq_prev_r  <= '0;
            tx_sync1_r  <= '0;
            tx_sync2_r  <= '0;
            tx_prev_r   <= '0;
            rx_sync1_r  <= '0;
            rx_sync2_r  <= '0;
            rx_prev_r   <= '0;
            led_cnt_r   <= '0;
            act_led_r   <= 1'b0;
        end else begin
            irq_sync1_r <= uart_irq;
            irq_sync2_r <= irq_sync1_r;
            irq_prev_r  <= irq_sync2_r;
            tx_sync1_r  <= txd;
            tx_sync2_r  <= tx_sync1_r;
            tx_prev_r   <= tx_sync2_r;
            rx_sync1_r  <= rxd;
            rx_sync2_r  <= rx_sync1_r;
            rx_prev_r   <= rx_sync2_r;
            led_cnt_r   <= led_cnt_next_s;
            act_led_r   <= (led_cnt_next_s != '0);
        end
    end

    assign uart_ce  = uart_ce_r;
    assign data_out = data_out_r;
    assign data_oe  = data_oe_r;
    assign irq      = irq_r;
    assign act_led  = act_led_r;

endmodule

// File: tb/tb_vicmidi_ser_router.sv
// Directed self-checking bench for vicmidi_ser_router (CHANNELS=2, LED_CNT_W=4).
module tb_vicmidi_ser_router;

    localparam int CHANNELS  = 2;
    localparam int LED_CNT_W = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        r_w;
    logic [9:0]  address;
    logic        io_sel;
    logic [6:0]  base;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [1:0]  uart_ce;
    logic [1:0]  txd;
    logic [1:0]  rxd;
    logic [1:0]  uart_irq;
    logic        midi_txd;
    logic        midi_rxd;
    logic        rs232_txd;
    logic        rs232_rxd;
    logic        irq;
    logic        act_led;

    int n_checks = 0;
    int n_fail   = 0;

    vicmidi_ser_router #(.CHANNELS(CHANNELS), .LED_CNT_W(LED_CNT_W)) dut (
        .clock(clock), .reset(reset), .r_w(r_w), .address(address), .io_sel(io_sel),
        .base(base), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .uart_ce(uart_ce), .txd(txd), .rxd(rxd), .uart_irq(uart_irq),
        .midi_txd(midi_txd), .midi_rxd(midi_rxd), .rs232_txd(rs232_txd),
        .rs232_rxd(rs232_rxd), .irq(irq), .act_led(act_led)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [7:0] val);
        address = {base + 7'd2, off};
        r_w     = 1'b0;
        data_in = val;
        io_sel  = 1'b0;
        tick();
        io_sel  = 1'b1;
        r_w     = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] val, output logic oe);
        address = {base + 7'd2, off};
        r_w     = 1'b1;
        io_sel  = 1'b0;
        tick();
        val     = data_out;
        oe      = data_oe;
        io_sel  = 1'b1;
    endtask

    logic [7:0] rd;
    logic       oe;
    int         led_cnt;

    initial begin
        reset = 1'b1; r_w = 1'b1; address = 10'h000; io_sel = 1'b1; base = 7'h10;
        data_in = 8'h00; txd = 2'b11; uart_irq = 2'b00; midi_rxd = 1'b1; rs232_rxd = 1'b1;
        repeat (3) tick();
        check_val("rst_uart_ce", uart_ce, 2'b00);
        check_val("rst_data_oe", data_oe, 1'b0);
        check_val("rst_data_out", data_out, 8'h00);
        check_val("rst_irq", irq, 1'b0);
        check_val("rst_act_led", act_led, 1'b0);
        reset = 1'b0;
        tick();

        // Decode
        address = 10'h080; io_sel = 1'b0; tick();
        check_val("ce_ch0", uart_ce, 2'b01);
        address = 10'h088; tick();
        check_val("ce_ch1", uart_ce, 2'b10);
        address = 10'h093; tick();
        check_val("id_data", data_out, 8'h12);
        check_val("id_oe", data_oe, 1'b1);
        check_val("win_ce", uart_ce, 2'b00);
        io_sel = 1'b1; tick();
        check_val("idle_oe", data_oe, 1'b0);
        check_val("idle_ce", uart_ce, 2'b00);
        base = 7'h7F; address = 10'h000; io_sel = 1'b0; tick();
        check_val("ce_wrap", uart_ce, 2'b10);
        address = 10'h3F8; tick();
        check_val("ce_top", uart_ce, 2'b01);
        io_sel = 1'b1; base = 7'h10; tick();
        bus_read(3'd5, rd, oe);
        check_val("off5_read", rd, 8'h00);

        // Modes and port ownership
        bus_read(3'd0, rd, oe);
        check_val("mode_rst", rd, 8'h0C);
        bus_write(3'd0, 8'h00);
        bus_read(3'd0, rd, oe);
        check_val("mode_00", rd, 8'h00);
        check_val("loser_rxd1", rxd[1], 1'b1);
        midi_rxd = 1'b0; #1;
        check_val("midi_rx_ch0", rxd[0], 1'b0);
        midi_rxd = 1'b1;
        txd[1] = 1'b0; #1;
        check_val("midi_loser_tx", midi_txd, 1'b1);
        txd[0] = 1'b0; #1;
        check_val("midi_owner_tx", midi_txd, 1'b0);
        txd = 2'b11;
        bus_write(3'd0, 8'h04);
        txd[1] = 1'b0; rs232_rxd = 1'b0; #1;
        check_val("rs232_tx_ch1", rs232_txd, 1'b0);
        check_val("rs232_rx_ch1", rxd[1], 1'b0);
        txd = 2'b11; rs232_rxd = 1'b1;
        bus_write(3'd0, 8'hFF);
        bus_read(3'd0, rd, oe);
        check_val("mode_ff", rd, 8'h0F);
        txd[0] = 1'b0; #1;
        check_val("midi_unowned", midi_txd, 1'b1);
        txd = 2'b11;

        // Loopback on ch1
        bus_write(3'd0, 8'h08);
        bus_read(3'd0, rd, oe);
        check_val("mode_loop", rd, 8'h08);
        txd[1] = 1'b0; #1;
`ifdef VICMIDI_LOOPBACK_EN
        check_val("loop_rxd1", rxd[1], 1'b0);
`else
        check_val("loop_rxd1", rxd[1], 1'b1);
`endif
        txd = 2'b11;

        // IRQ
        bus_write(3'd1, 8'h02);
        bus_read(3'd1, rd, oe);
        check_val("mask_rd", rd, 8'h02);
        uart_irq[1] = 1'b1; tick(); tick(); uart_irq[1] = 1'b0; tick();
        check_val("irq_early", irq, 1'b0);
        tick();
        check_val("irq_set", irq, 1'b1);
        bus_read(3'd2, rd, oe);
        check_val("pend_set", rd, 8'h02);
        bus_write(3'd2, 8'h02);
        bus_read(3'd2, rd, oe);
        check_val("pend_clr", rd, 8'h00);
        tick();
        check_val("irq_clr", irq, 1'b0);
        uart_irq[1] = 1'b1; tick(); tick(); uart_irq[1] = 1'b0;
        bus_write(3'd2, 8'h02);
        bus_read(3'd2, rd, oe);
        check_val("pend_set_wins", rd, 8'h02);
        uart_irq[0] = 1'b1; tick(); tick(); uart_irq[0] = 1'b0;
        repeat (3) tick();
        bus_read(3'd2, rd, oe);
        check_val("pend_both", rd, 8'h03);
        bus_write(3'd2, 8'h02);
        repeat (2) tick();
        check_val("irq_masked", irq, 1'b0);
        uart_irq[1] = 1'b1; tick(); tick(); uart_irq[1] = 1'b0;
        repeat (3) tick();
        check_val("irq_before_rst", irq, 1'b1);

        // Mid-operation reset
        reset = 1'b1; tick(); reset = 1'b0;
        check_val("mrst_irq", irq, 1'b0);
        check_val("mrst_oe", data_oe, 1'b0);
        bus_read(3'd0, rd, oe);
        check_val("mrst_mode", rd, 8'h0C);
        bus_read(3'd2, rd, oe);
        check_val("mrst_pend", rd, 8'h00);
        bus_read(3'd1, rd, oe);
        check_val("mrst_mask", rd, 8'h00);

        // LED stretch
        repeat (20) tick();
        check_val("led_quiet", act_led, 1'b0);
        txd[0] = 1'b0;
        led_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (act_led) led_cnt++;
        end
        check_val("led_high_cycles", led_cnt, 15);
        check_val("led_expired", act_led, 1'b0);
        txd[1] = 1'b0;
        repeat (6) tick();
        check_val("led_off_chan", act_led, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
